keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner_pkg.sv | 30 +++
 rtl/keypad_keymap.sv | 33 +++
 rtl/keypad_scanner.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared keypad constants, FSM state encoding and small bit helpers.
package keypad_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_DB,
        ST_HELD,
        ST_RELEASE_DB
    } kp_state_e;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    // Bit 4 set marks "no single key this frame"; every 4-bit code is a real key.
    localparam logic [4:0] KEY_NONE = 5'h10;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        if (v[0])      idx = 2'd0;
        else if (v[1]) idx = 2'd1;
        else if (v[2]) idx = 2'd2;
        else if (v[3]) idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_keymap.sv
// Combinational 4x4 keypad map: (row, col) -> key code.
module keypad_keymap
    import keypad_scanner_pkg::*;
(
    input  logic [1:0] row_idx,
    input  logic [1:0] col_idx,
    output logic [3:0] code
);

    always_comb begin
        code = 4'h0;
        case ({row_idx, col_idx})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'h0;
            4'hE: code = KEY_HASH;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
    end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader with per-frame ghost rejection and
// frame-based press/release debounce.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 12000,
    parameter int unsigned DEBOUNCE_FRAMES = 5
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic [3:0] IO_P4_ROW,
    output logic [3:0] IO_P4_COL,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down
);

    localparam int unsigned SW = $clog2(SCAN_DIV);
    localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    row_meta_q, row_meta_d;
    logic [3:0]    row_sync_q, row_sync_d;
    logic [1:0]    acc_cnt_q, acc_cnt_d;
    logic [1:0]    acc_row_q, acc_row_d;
    logic [1:0]    acc_col_q, acc_col_d;

    kp_state_e     state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;
    logic [CW-1:0] rel_cnt_q, rel_cnt_d;
    logic [3:0]    key_code_q, key_code_d;
    logic          key_valid_q, key_valid_d;

    logic          sample, frame_end;
    logic [3:0]    pressed;
    logic [2:0]    hits;
    logic [1:0]    merged_cnt, merged_row, merged_col;
    logic [3:0]    map_code;
    logic [4:0]    frame_key;

    keypad_keymap u_keymap (
        .row_idx (merged_row),
        .col_idx (merged_col),
        .code    (map_code)
    );

    always_comb begin
        sample     = (slot_q == SLOT_LAST);
        frame_end  = sample && (col_q == 2'd3);
        slot_d     = sample ? '0 : slot_q + 1'b1;
        col_d      = sample ? col_q + 2'd1 : col_q;
        row_meta_d = IO_P4_ROW;
        row_sync_d = row_meta_q;

        pressed    = ~row_sync_q;
        hits       = popcount4(pressed);

        // Accumulator count saturates at 2, which already means "reject frame".
        merged_cnt = acc_cnt_q;
        merged_row = acc_row_q;
        merged_col = acc_col_q;
        if (hits >= 3'd2) begin
            merged_cnt = 2'd2;
        end else if (hits == 3'd1) begin
            if (acc_cnt_q == 2'd0) begin
                merged_cnt = 2'd1;
                merged_row = lowest_set(pressed);
                merged_col = col_q;
            end else begin
                merged_cnt = 2'd2;
            end
        end

        frame_key = (merged_cnt == 2'd1) ? {1'b0, map_code} : KEY_NONE;

        acc_cnt_d = acc_cnt_q;
        acc_row_d = acc_row_q;
        acc_col_d = acc_col_q;
        if (frame_end) begin
            acc_cnt_d = '0;
            acc_row_d = '0;
            acc_col_d = '0;
        end else if (sample) begin
            acc_cnt_d = merged_cnt;
            acc_row_d = merged_row;
            acc_col_d = merged_col;
        end
    end

    always_comb begin
        logic          accept;
        logic [CW-1:0] stable_inc, rel_inc;

        state_d      = state_q;
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        rel_cnt_d    = rel_cnt_q;
        key_code_d   = key_code_q;
        key_valid_d  = 1'b0;
        accept       = 1'b0;
        stable_inc   = (stable_cnt_q < DB_MAX) ? stable_cnt_q + 1'b1 : DB_MAX;
        rel_inc      = (rel_cnt_q < DB_MAX) ? rel_cnt_q + 1'b1 : DB_MAX;

        if (frame_end) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_key != KEY_NONE) begin
                        cand_d       = frame_key[3:0];
                        stable_cnt_d = CNT_ONE;
                        if (CNT_ONE == DB_MAX) accept = 1'b1;
                        else                   state_d = ST_PRESS_DB;
                    end
                end
                ST_PRESS_DB: begin
                    if (frame_key == KEY_NONE) begin
                        state_d      = ST_IDLE;
                        stable_cnt_d = '0;
                    end else if (frame_key[3:0] == cand_q) begin
                        stable_cnt_d = stable_inc;
                        if (stable_inc == DB_MAX) accept = 1'b1;
                    end else begin
                        cand_d       = frame_key[3:0];
                        stable_cnt_d = CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (frame_key != {1'b0, key_code_q}) begin
                        if (CNT_ONE == DB_MAX) begin
                            state_d   = ST_IDLE;
                            rel_cnt_d = '0;
                        end else begin
                            state_d   = ST_RELEASE_DB;
                            rel_cnt_d = CNT_ONE;
                        end
                    end
                end
                ST_RELEASE_DB: begin
                    if (frame_key == {1'b0, key_code_q}) begin
                        state_d   = ST_HELD;
                        rel_cnt_d = '0;
                    end else if (rel_inc == DB_MAX) begin
                        state_d   = ST_IDLE;
                        rel_cnt_d = '0;
                    end else begin
                        rel_cnt_d = rel_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (accept) begin
            state_d      = ST_HELD;
            key_code_d   = cand_d;
            key_valid_d  = 1'b1;
            stable_cnt_d = '0;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            slot_q       <= '0;
            col_q        <= '0;
            row_meta_q   <= '0;
            row_sync_q   <= '0;
            acc_cnt_q    <= '0;
            acc_row_q    <= '0;
            acc_col_q    <= '0;
            state_q      <= ST_IDLE;
            cand_q       <= '0;
            stable_cnt_q <= '0;
            rel_cnt_q    <= '0;
            key_code_q   <= '0;
            key_valid_q  <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            col_q        <= col_d;
            row_meta_q   <= row_meta_d;
            row_sync_q   <= row_sync_d;
            acc_cnt_q    <= acc_cnt_d;
            acc_row_q    <= acc_row_d;
            acc_col_q    <= acc_col_d;
            state_q      <= state_d;
            cand_q       <= cand_d;
            stable_cnt_q <= stable_cnt_d;
            rel_cnt_q    <= rel_cnt_d;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
        end
    end

    assign IO_P4_COL = ~(4'b0001 << col_q);
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = (state_q == ST_HELD) || (state_q == ST_RELEASE_DB);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_FRAMES=2 (16-cycle frames);
// a behavioural keypad matrix pulls rows low for pressed keys in the driven column.
module tb_keypad_scanner;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  IO_P4_ROW;
    logic [3:0]  IO_P4_COL;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;

    // Bit r*4+c set means the key at row r, column c is held.
    logic [15:0] keys = '0;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned n_pulses = 0;

    localparam logic [15:0] K_NONE = 16'h0000;
    localparam logic [15:0] K_8    = 16'h0001 << 9;
    localparam logic [15:0] K_STAR = 16'h0001 << 12;
    localparam logic [15:0] K_5    = 16'h0001 << 5;
    localparam logic [15:0] K_1    = 16'h0001 << 0;
    localparam logic [15:0] K_9    = 16'h0001 << 10;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (2)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .IO_P4_ROW (IO_P4_ROW),
        .IO_P4_COL (IO_P4_COL),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    always #5 Clk = ~Clk;

    for (genvar r = 0; r < 4; r++) begin : g_row
        assign IO_P4_ROW[r] = ~|(keys[r*4 +: 4] & ~IO_P4_COL);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
        if (!reset && key_valid) n_pulses++;
    endtask

    // Holds the key pattern for one full frame; returns at the negedge right
    // after that frame's end, where its result is visible on the outputs.
    task automatic do_frame(input logic [15:0] k);
        keys = k;
        repeat (16) tick();
    endtask

    task automatic expect_out(input string tag, input logic v, input logic d, input logic [3:0] c);
        check({tag, ".valid"}, {31'd0, key_valid}, {31'd0, v});
        check({tag, ".down"},  {31'd0, key_down},  {31'd0, d});
        check({tag, ".code"},  {28'd0, key_code},  {28'd0, c});
    endtask

    initial begin
        logic [3:0] exp_col;

        repeat (3) @(negedge Clk);
        check("rst.col", {28'd0, IO_P4_COL}, 32'he);
        expect_out("rst", 1'b0, 1'b0, 4'h0);
        reset = 1'b0;

        // Idle scan: column advances every 4 cycles, two full frames.
        for (int i = 0; i < 32; i++) begin
            tick();
            exp_col = ~(4'b0001 << (((i + 1) / 4) % 4));
            check("idle.col", {28'd0, IO_P4_COL}, {28'd0, exp_col});
        end
        check("idle.pulses", n_pulses, 0);

        // Steady key 8: accepted after the 2nd frame, no repeat while held.
        do_frame(K_8);  expect_out("k8.f1", 1'b0, 1'b0, 4'h0);
        do_frame(K_8);  expect_out("k8.f2", 1'b1, 1'b1, 4'h8);
        do_frame(K_8);  expect_out("k8.f3", 1'b0, 1'b1, 4'h8);
        do_frame(K_8);
        do_frame(K_8);  expect_out("k8.f5", 1'b0, 1'b1, 4'h8);
        check("k8.pulses", n_pulses, 1);
        do_frame(K_NONE); expect_out("k8.rel1", 1'b0, 1'b1, 4'h8);
        do_frame(K_NONE); expect_out("k8.rel2", 1'b0, 1'b0, 4'h8);

        // Bouncing '*': present, absent, present, present.
        do_frame(K_STAR); expect_out("star.f1", 1'b0, 1'b0, 4'h8);
        do_frame(K_NONE); expect_out("star.f2", 1'b0, 1'b0, 4'h8);
        do_frame(K_STAR); expect_out("star.f3", 1'b0, 1'b0, 4'h8);
        do_frame(K_STAR); expect_out("star.f4", 1'b1, 1'b1, 4'hE);
        check("star.pulses", n_pulses, 2);
        do_frame(K_NONE);
        do_frame(K_NONE); expect_out("star.rel", 1'b0, 1'b0, 4'hE);

        // Key 5 with a single-frame dropout that must not release it.
        do_frame(K_5);    expect_out("k5.f1", 1'b0, 1'b0, 4'hE);
        do_frame(K_5);    expect_out("k5.f2", 1'b1, 1'b1, 4'h5);
        do_frame(K_NONE); expect_out("k5.gap", 1'b0, 1'b1, 4'h5);
        do_frame(K_5);    expect_out("k5.back", 1'b0, 1'b1, 4'h5);
        do_frame(K_NONE); expect_out("k5.rel1", 1'b0, 1'b1, 4'h5);
        do_frame(K_NONE); expect_out("k5.rel2", 1'b0, 1'b0, 4'h5);
        check("k5.pulses", n_pulses, 3);

        // Keys 1 and 9 together are rejected; dropping 9 lets 1 through.
        do_frame(K_1 | K_9); expect_out("multi.f1", 1'b0, 1'b0, 4'h5);
        do_frame(K_1 | K_9);
        do_frame(K_1 | K_9); expect_out("multi.f3", 1'b0, 1'b0, 4'h5);
        check("multi.pulses", n_pulses, 3);
        do_frame(K_1);    expect_out("k1.f1", 1'b0, 1'b0, 4'h5);
        do_frame(K_1);    expect_out("k1.f2", 1'b1, 1'b1, 4'h1);
        do_frame(K_NONE);
        do_frame(K_NONE); expect_out("k1.rel", 1'b0, 1'b0, 4'h1);
        check("k1.pulses", n_pulses, 4);

        // Reset in the middle of a press debounce.
        do_frame(K_8);    expect_out("mid.f1", 1'b0, 1'b0, 4'h1);
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("mid.rst.col", {28'd0, IO_P4_COL}, 32'he);
        expect_out("mid.rst", 1'b0, 1'b0, 4'h0);
        repeat (2) tick();
        reset = 1'b0;
        do_frame(K_8);    expect_out("post.f1", 1'b0, 1'b0, 4'h0);
        do_frame(K_8);    expect_out("post.f2", 1'b1, 1'b1, 4'h8);
        check("post.pulses", n_pulses, 5);

        // Switching straight to key 5 needs a full release, then a new debounce.
        do_frame(K_5);    expect_out("sw.f1", 1'b0, 1'b1, 4'h8);
        do_frame(K_5);    expect_out("sw.f2", 1'b0, 1'b0, 4'h8);
        do_frame(K_5);    expect_out("sw.f3", 1'b0, 1'b0, 4'h8);
        do_frame(K_5);    expect_out("sw.f4", 1'b1, 1'b1, 4'h5);
        check("sw.pulses", n_pulses, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
